// File: rtl/stride_read_master_if.sv
// AXI read address/data channel bundle between a read master and its slave.
interface stride_read_master_if #(
  parameter int ADDR_BITS       = 64,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int TID_WIDTH       = 8,
  parameter int DATA_WIDTH      = 8
);
  logic                       m_ar_valid;
  logic                       m_ar_ready;
  logic [ADDR_BITS-1:0]       m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0] m_ar_len;
  logic [TID_WIDTH-1:0]       m_ar_id;
  logic                       m_r_valid;
  logic                       m_r_ready;
  logic [DATA_WIDTH-1:0]      m_r_data;
  logic                       m_r_last;
  logic [TID_WIDTH-1:0]       m_r_id;

  modport master (
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
  );

  modport slave (
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
  );
endinterface

// File: rtl/stride_read_master.sv
// Strided AXI read burst generator with outstanding-burst limit, R-beat ID/LAST
// checking and an XOR signature over all accepted read data.
module stride_read_master #(
  parameter int ADDR_BITS            = 64,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int OUTST_WIDTH          = 3,
  parameter int REQ_CNT_WIDTH        = 16
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               start,
  input  logic [ADDR_BITS-1:0]               cfg_base,
  input  logic [ADDR_BITS-1:0]               cfg_stride,
  input  logic [REQ_CNT_WIDTH-1:0]           cfg_num_reqs,
  input  logic [BURST_LEN_WIDTH-1:0]         cfg_len,
  input  logic [TID_WIDTH-1:0]               cfg_id,
  input  logic [OUTST_WIDTH-1:0]             cfg_max_outst,
  stride_read_master_if.master               bus,
  output logic                               busy,
  output logic                               done,
  output logic [REQ_CNT_WIDTH-1:0]           beat_cnt,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] data_sig,
  output logic                               err_id,
  output logic                               err_last
);
  localparam int DATA_W = 8 << LOG_BLOCK_DATA_BYTES;
  localparam logic [REQ_CNT_WIDTH-1:0]   REQ_ONE = 1;
  localparam logic [OUTST_WIDTH-1:0]     OUT_ONE = 1;
  localparam logic [BURST_LEN_WIDTH:0]   BB_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d, stride_q, stride_d;
  logic [REQ_CNT_WIDTH-1:0]   num_q, num_d, issued_q, issued_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [OUTST_WIDTH-1:0]     max_q, max_d, outst_q, outst_d, max_eff_d;
  logic [BURST_LEN_WIDTH:0]   bbeat_q, bbeat_d, beat_no, len_plus1;
  logic [REQ_CNT_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]          data_sig_q, data_sig_d;
  logic                       err_id_q, err_id_d, err_last_q, err_last_d;
  logic                       ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
  logic                       busy_q, busy_d, done_q, done_d;

  logic start_ok, ar_fire, r_fire, r_close;

  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign ar_fire   = ar_valid_q && bus.m_ar_ready;
  assign r_fire    = r_ready_q && bus.m_r_valid;
  // A LAST with nothing outstanding is a protocol error and must not underflow.
  assign r_close   = r_fire && bus.m_r_last && (outst_q != '0);
  assign len_plus1 = {1'b0, len_q} + BB_ONE;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (cfg_num_reqs == '0) ? S_DONE : S_RUN;
      S_RUN:          if (issued_d == num_q) state_d = S_DRAIN;
      S_DRAIN:        if (outst_d == '0) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    max_eff_d  = (max_d == '0) ? OUT_ONE : max_d;
    ar_valid_d = (state_d == S_RUN) && (issued_d < num_d) && (outst_d < max_eff_d);
    r_ready_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d     = r_ready_d;
    done_d     = (state_d == S_DONE);
  end

  always_comb begin
    addr_d     = addr_q;
    stride_d   = stride_q;
    num_d      = num_q;
    len_d      = len_q;
    id_d       = id_q;
    max_d      = max_q;
    issued_d   = issued_q;
    outst_d    = outst_q;
    bbeat_d    = bbeat_q;
    beat_cnt_d = beat_cnt_q;
    data_sig_d = data_sig_q;
    err_id_d   = err_id_q;
    err_last_d = err_last_q;
    beat_no    = bbeat_q + BB_ONE;
    if (start_ok) begin
      addr_d     = cfg_base;
      stride_d   = cfg_stride;
      num_d      = cfg_num_reqs;
      len_d      = cfg_len;
      id_d       = cfg_id;
      max_d      = cfg_max_outst;
      issued_d   = '0;
      outst_d    = '0;
      bbeat_d    = '0;
      beat_cnt_d = '0;
      data_sig_d = '0;
      err_id_d   = 1'b0;
      err_last_d = 1'b0;
    end else begin
      if (ar_fire) begin
        addr_d   = addr_q + stride_q;
        issued_d = issued_q + REQ_ONE;
      end
      if (r_fire) begin
        beat_cnt_d = beat_cnt_q + REQ_ONE;
        data_sig_d = data_sig_q ^ bus.m_r_data;
        if (bus.m_r_id != id_q) err_id_d = 1'b1;
        if (bus.m_r_last) begin
          bbeat_d = '0;
          if ((outst_q == '0) || (beat_no < len_plus1)) err_last_d = 1'b1;
        end else begin
          if (beat_no == len_plus1) err_last_d = 1'b1;
          // Saturate so an endless burst cannot wrap and look well-formed.
          if (!(&bbeat_q)) bbeat_d = beat_no;
        end
      end
      if (ar_fire && !r_close) begin
        outst_d = outst_q + OUT_ONE;
      end else if (!ar_fire && r_close) begin
        outst_d = outst_q - OUT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_q     <= '0;
      stride_q   <= '0;
      num_q      <= '0;
      len_q      <= '0;
      id_q       <= '0;
      max_q      <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      bbeat_q    <= '0;
      beat_cnt_q <= '0;
      data_sig_q <= '0;
      err_id_q   <= 1'b0;
      err_last_q <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      num_q      <= num_d;
      len_q      <= len_d;
      id_q       <= id_d;
      max_q      <= max_d;
      issued_q   <= issued_d;
      outst_q    <= outst_d;
      bbeat_q    <= bbeat_d;
      beat_cnt_q <= beat_cnt_d;
      data_sig_q <= data_sig_d;
      err_id_q   <= err_id_d;
      err_last_q <= err_last_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.m_ar_valid = ar_valid_q;
  assign bus.m_ar_addr  = addr_q;
  assign bus.m_ar_len   = len_q;
  assign bus.m_ar_id    = id_q;
  assign bus.m_r_ready  = r_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign beat_cnt       = beat_cnt_q;
  assign data_sig       = data_sig_q;
  assign err_id         = err_id_q;
  assign err_last       = err_last_q;
endmodule

// File: doc/stride_read_master.md
Name: stride_read_master

Overview:
- Upstream AXI read-channel traffic source that drives the prefetcher's slave-side read ports (s_ar_*, s_r_*).
- Issues a programmed sequence of strided read bursts and enforces an outstanding-burst limit.
- Checks returned R beats for ID and LAST correctness, and accumulates a data signature.
- Replaces hand-written stimulus loops in prefetcher benches and serves as the on-chip stride traffic generator.

Parameters:
ADDR_BITS, 64, address width
BURST_LEN_WIDTH, 8, AXI len width (beats = len+1)
TID_WIDTH, 8, transaction ID width
LOG_BLOCK_DATA_BYTES, 0, log2 of data bytes per beat; data width = 8<<LOG_BLOCK_DATA_BYTES
OUTST_WIDTH, 3, outstanding counter width; max usable limit 2^OUTST_WIDTH-1
REQ_CNT_WIDTH, 16, request/beat counter width

Ports:
clk  in  1  clock, rising edge
resetN  in  1  asynchronous active-low reset
start  in  1  begin a run; honoured only in IDLE or DONE
cfg_base  in  ADDR_BITS  first burst address
cfg_stride  in  ADDR_BITS  address increment per burst, added modulo 2^ADDR_BITS
cfg_num_reqs  in  REQ_CNT_WIDTH  number of bursts to issue
cfg_len  in  BURST_LEN_WIDTH  AXI len for every burst
cfg_id  in  TID_WIDTH  ARID used and expected on RID
cfg_max_outst  in  OUTST_WIDTH  outstanding-burst limit; 0 is treated as 1
m_ar_valid  out  1  read address valid
m_ar_ready  in  1  read address ready
m_ar_addr  out  ADDR_BITS  burst address
m_ar_len  out  BURST_LEN_WIDTH  burst length
m_ar_id  out  TID_WIDTH  burst ID
m_r_valid  in  1  read data valid
m_r_ready  out  1  read data ready
m_r_data  in  8<<LOG_BLOCK_DATA_BYTES  read data
m_r_last  in  1  last beat of burst
m_r_id  in  TID_WIDTH  read ID
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
beat_cnt  out  REQ_CNT_WIDTH  total R beats accepted in the current run
data_sig  out  8<<LOG_BLOCK_DATA_BYTES  XOR of all accepted beat data
err_id  out  1  sticky: RID != cfg_id on an accepted beat
err_last  out  1  sticky: LAST asserted early, or missing on the (len+1)th beat

Behaviour:
- Clocking and reset:
  - All state and outputs are registered; reset is asynchronous and active-low.
  - Reset values: state=IDLE; m_ar_valid=0; m_ar_addr/len/id=0; m_r_ready=0; busy=0; done=0; beat_cnt=0; data_sig=0; err_id=0; err_last=0; all internal counters 0.
  - Reset mid-run abandons all transactions with no completion; the bench must also reset the slave.
- State machine:
  - IDLE/DONE + start: latch all cfg_* inputs, clear beat_cnt, data_sig, err_*, issued count, outstanding count, and per-burst beat counter; set addr=cfg_base. Go to RUN, or to DONE if cfg_num_reqs==0.
  - RUN: issue bursts. Once issued==num_reqs, go to DRAIN.
  - DRAIN: go to DONE when outstanding==0.
  - start in RUN or DRAIN is ignored.
- Latency: start sampled at edge t gives busy=1 and m_ar_valid=1 (if issuable) after edge t; the first AR can handshake at edge t+1.
- AR channel:
  - m_ar_valid=1 in RUN when issued<num_reqs and outstanding<max(cfg_max_outst,1).
  - addr/len/id are held stable while valid && !ready; valid is never withdrawn before the handshake.
  - On handshake: addr+=stride (wraps modulo 2^ADDR_BITS), issued+=1, outstanding+=1. Back-to-back handshakes on consecutive cycles are allowed.
- R channel:
  - m_r_ready=1 in RUN and DRAIN, 0 otherwise.
  - On each accepted beat: beat_cnt+=1 (wraps), data_sig^=data; per-burst beat counter increments.
  - LAST asserted before beat len+1 sets err_last and closes the burst. LAST absent on beat len+1 sets err_last and the counter keeps counting until LAST.
  - Outstanding decrements only on an accepted beat with m_r_last=1.
  - AR handshake and R-last in the same cycle leave outstanding unchanged.
  - R-last with outstanding==0 is a protocol error: set err_last, keep the counter at 0.
- Errors are sticky until the next accepted start; they do not stop the run.
- done stays high until a new start is accepted, then drops on the next edge.

Test Plan:
- Single burst: base=0xdeadbeef, stride=0x10, num=1, len=1, id=5, max=3, slave returns 0x11,0x22 (last on 2nd) -> one AR addr 0xdeadbeef len 1 id 5; beat_cnt=2; data_sig=0x33; done=1; errors 0.
- Stride + limit: num=6, stride=0x40, max=2, slave with 4-cycle latency -> AR addrs base, +0x40 … +0x140 in order; outstanding never exceeds 2; beat_cnt=12.
- AR backpressure: m_ar_ready low for 5 cycles -> addr/len/id stable and valid held; issue resumes once ready rises.
- ID/LAST faults: RID=6 on one beat -> err_id=1; LAST on beat 1 of len=1 -> err_last=1; run still completes with done=1.
- Edge cases: num=0 -> DONE after 1 cycle with no AR; base=0xFFFF_FFFF_FFFF_FFF0, stride=0x20, num=2 -> 2nd addr 0x10; reset asserted mid-DRAIN -> all outputs at reset values immediately.
